// File: rtl/ldpc_cshift_pkg.sv
// Shared constants and helpers for the LDPC circulant shifters.
// Both the right shifter and the unshifter use this package.
package ldpc_cshift_pkg;

  localparam int DEFAULT_MAXZ = 81;

  function automatic int num_stages(input int maxz, input int rotates_per_cycle);
    return ($clog2(maxz) + rotates_per_cycle - 1) / rotates_per_cycle;
  endfunction

  // Rotation contributed by level idx, folded into [0, maxz) so oversized shifts wrap.
  function automatic int rot_amount(input int idx, input int maxz);
    int r;
    r = 1 % maxz;
    for (int i = 0; i < idx; i++) begin
      r = (r * 2) % maxz;
    end
    return r;
  endfunction

endpackage

// File: rtl/pipelined_circular_unshifter_unrotate_stage.sv
// One conditional left-rotate level of the circulant unshifter.
// PASS_THROUGH marks levels beyond the shift-value width.
module unrotate_stage
  import ldpc_cshift_pkg::*;
#(
  parameter int MAXZ         = DEFAULT_MAXZ,
  parameter int ROT          = 1,
  parameter bit PASS_THROUGH = 1'b0
) (
  input  logic            i_en,
  input  logic [MAXZ-1:0] i_data,
  output logic [MAXZ-1:0] o_data
);

  logic [MAXZ-1:0] w_rot;

  generate
    if (PASS_THROUGH || ROT == 0) begin : g_pass
      assign w_rot = i_data;
    end else begin : g_rot
      assign w_rot = (i_data << ROT) | (i_data >> (MAXZ - ROT));
    end
  endgenerate

  assign o_data = i_en ? w_rot : i_data;

endmodule

// File: rtl/pipelined_circular_unshifter.sv
// Pipelined left circular rotate that undoes the right circulant shifter, valid/ready on both sides.
// Optional macro CSHIFT_RANGE_CHECK_EN adds err_out/err_sticky and zeroes beats whose shift is >= MAXZ.
module pipelined_circular_unshifter
  import ldpc_cshift_pkg::*;
#(
  parameter int MAXZ              = DEFAULT_MAXZ,
  parameter int ROTATES_PER_CYCLE = 2,
  parameter int TAG_W             = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  output logic                    ready_out,
  input  logic [MAXZ-1:0]         in_data,
  input  logic [$clog2(MAXZ)-1:0] shift_val,
  input  logic [TAG_W-1:0]        tag_in,
  output logic [MAXZ-1:0]         out_data,
  output logic [TAG_W-1:0]        tag_out,
  output logic                    valid_out,
  input  logic                    ready_in
`ifdef CSHIFT_RANGE_CHECK_EN
  ,
  output logic                    err_out,
  output logic                    err_sticky
`endif
);

  localparam int SW  = $clog2(MAXZ);
  localparam int RPC = ROTATES_PER_CYCLE;
  localparam int NS  = num_stages(MAXZ, ROTATES_PER_CYCLE);

  generate
    if (ROTATES_PER_CYCLE < 1) begin : g_bad_rpc
      $error("ROTATES_PER_CYCLE must be at least 1");
    end
  endgenerate

  logic [MAXZ-1:0]  r_data  [NS];
  logic [TAG_W-1:0] r_tag   [NS];
  logic [SW-1:0]    r_shift [NS];
  logic             r_valid [NS];

  logic [NS-1:0]    w_adv;
  logic [NS-1:0]    w_vIn;
  logic [MAXZ-1:0]  w_stageIn [NS];
  logic [TAG_W-1:0] w_tagIn   [NS];
  logic [SW-1:0]    w_shIn    [NS];
  logic [MAXZ-1:0]  w_lvl     [NS][RPC+1];
  logic [MAXZ-1:0]  w_next    [NS];

`ifdef CSHIFT_RANGE_CHECK_EN
  logic             r_err [NS];
  logic [NS-1:0]    w_errIn;
  logic             r_errSticky;
`endif

  genvar k, m;
  generate
    for (k = 0; k < NS; k++) begin : g_stage
      if (k == 0) begin : g_head
        assign w_stageIn[k] = in_data;
        assign w_tagIn[k]   = tag_in;
        assign w_shIn[k]    = shift_val;
        assign w_vIn[k]     = valid_in;
`ifdef CSHIFT_RANGE_CHECK_EN
        assign w_errIn[k]   = (int'(shift_val) >= MAXZ);
`endif
      end else begin : g_body
        assign w_stageIn[k] = r_data[k-1];
        assign w_tagIn[k]   = r_tag[k-1];
        assign w_shIn[k]    = r_shift[k-1];
        assign w_vIn[k]     = r_valid[k-1];
`ifdef CSHIFT_RANGE_CHECK_EN
        assign w_errIn[k]   = r_err[k-1];
`endif
      end

      // Each stage moves when empty or when its successor moves, so bubbles collapse.
      if (k == NS - 1) begin : g_tail_adv
        assign w_adv[k] = !r_valid[k] || ready_in;
      end else begin : g_mid_adv
        assign w_adv[k] = !r_valid[k] || w_adv[k+1];
      end

      assign w_lvl[k][0] = w_stageIn[k];
      for (m = 0; m < RPC; m++) begin : g_level
        localparam int IDX = k * RPC + m;
        if (IDX < SW) begin : g_live
          unrotate_stage #(
            .MAXZ(MAXZ), .ROT(rot_amount(IDX, MAXZ)), .PASS_THROUGH(1'b0)
          ) u_level (
            .i_en(w_shIn[k][IDX]), .i_data(w_lvl[k][m]), .o_data(w_lvl[k][m+1])
          );
        end else begin : g_pass
          unrotate_stage #(
            .MAXZ(MAXZ), .ROT(0), .PASS_THROUGH(1'b1)
          ) u_level (
            .i_en(1'b0), .i_data(w_lvl[k][m]), .o_data(w_lvl[k][m+1])
          );
        end
      end

`ifdef CSHIFT_RANGE_CHECK_EN
      if (k == NS - 1) begin : g_zero
        assign w_next[k] = w_errIn[k] ? '0 : w_lvl[k][RPC];
      end else begin : g_keep
        assign w_next[k] = w_lvl[k][RPC];
      end
`else
      assign w_next[k] = w_lvl[k][RPC];
`endif

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_valid[k] <= 1'b0;
          r_data[k]  <= '0;
          r_tag[k]   <= '0;
`ifdef CSHIFT_RANGE_CHECK_EN
          r_err[k]   <= 1'b0;
`endif
        end else if (w_adv[k]) begin
          r_valid[k] <= w_vIn[k];
          r_data[k]  <= w_next[k];
          r_tag[k]   <= w_tagIn[k];
`ifdef CSHIFT_RANGE_CHECK_EN
          r_err[k]   <= w_errIn[k];
`endif
        end
      end

      // The final stage has no successor, so it never needs the shift value.
      if (k < NS - 1) begin : g_shreg
        always_ff @(posedge clk) begin
          if (!rst_n) begin
            r_shift[k] <= '0;
          end else if (w_adv[k]) begin
            r_shift[k] <= w_shIn[k];
          end
        end
      end
    end
  endgenerate

  assign ready_out = w_adv[0] || !rst_n;
  assign out_data  = r_data[NS-1];
  assign tag_out   = r_tag[NS-1];
  assign valid_out = r_valid[NS-1];

`ifdef CSHIFT_RANGE_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_errSticky <= 1'b0;
    end else if (w_adv[NS-1] && w_vIn[NS-1] && w_errIn[NS-1]) begin
      r_errSticky <= 1'b1;
    end
  end

  assign err_out    = r_valid[NS-1] && r_err[NS-1];
  assign err_sticky = r_errSticky;
`endif

endmodule
